// File: rtl/regfile_arb_pkg.sv
// Shared defaults and constants for the register-file write-back arbiter.
package regfile_arb_pkg;
  localparam int NUM_REQ_DEF = 3;
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int PTR_W       = 3;
  localparam int REG_ZERO    = 0;
  localparam int CNT_W       = 8;
  localparam logic [CNT_W-1:0] DROP_CNT_MAX = 8'hFF;
endpackage

// File: rtl/wb_rr_pick.sv
// Pointer-rotated one-hot pick: lowest valid index at or after ptr, wrapping.
module wb_rr_pick
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  int first;
  int sum;

  always_comb begin
    rot   = NUM_REQ'({valid, valid} >> ptr);
    any   = |rot;
    first = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) first = j;
    end
    sum = int'(ptr) + first;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    grant_idx = PTR_W'(sum);
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = any && (sum == i);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-back arbiter with registered output stage and r0-drop counter.
// REGFILE_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority (index 0 highest).
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_stall,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  output logic [2:0]                grant_id,
  output logic [CNT_W-1:0]          r0_drop_cnt
);

  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic [PTR_W-1:0]   ptr;
  logic               accept;
  logic               to_r0;
  logic [ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]  sel_data;

  wb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid     (req_valid),
    .ptr       (ptr),
    .grant     (pick),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // Reset gates ready so a request pending across reset is never consumed.
  assign accept    = pick_any && !wb_stall && ctrl_reset;
  assign req_ready = accept ? pick : '0;

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_reg  = sel_reg  | req_reg[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign to_r0 = (sel_reg == ADDR_W'(REG_ZERO));

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr_q;

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      grant_id         <= '0;
    end else if (wb_stall) begin
      ctrl_writeEnable <= 1'b0;
    end else if (accept) begin
      ctrl_writeEnable <= !to_r0;
      ctrl_writeReg    <= sel_reg;
      data_writeReg    <= sel_data;
      grant_id         <= pick_idx;
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      r0_drop_cnt <= '0;
    end else if (accept && to_r0 && r0_drop_cnt != DROP_CNT_MAX) begin
      r0_drop_cnt <= r0_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Table-driven, scoreboarded bench for regfile_write_arbiter (NUM_REQ=3, DATA_W=32, ADDR_W=5).
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic [2:0]  valid;
    logic [4:0]  r0, r1, r2;
    logic [31:0] d0, d1, d2;
    logic        stall;
    logic [2:0]  ready;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [2:0]  gid;
    logic [7:0]  cnt;
  } vec_t;

  logic         clock;
  logic         ctrl_reset;
  logic [2:0]   req_valid;
  logic [14:0]  req_reg;
  logic [95:0]  req_data;
  logic [2:0]   req_ready;
  logic         wb_stall;
  logic         ctrl_writeEnable;
  logic [4:0]   ctrl_writeReg;
  logic [31:0]  data_writeReg;
  logic [2:0]   grant_id;
  logic [7:0]   r0_drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t tbl[$];
  vec_t exp_q[$];
  logic [31:0] rf [32];

  logic [4:0]  cr0, cr1, cr2;
  logic [31:0] cd0, cd1, cd2;

  regfile_write_arbiter dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .wb_stall         (wb_stall),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .grant_id         (grant_id),
    .r0_drop_cnt      (r0_drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference register file fed by the DUT's write port.
  always @(posedge clock) begin
    if (ctrl_writeEnable === 1'b1) rf[ctrl_writeReg] <= data_writeReg;
  end

  function automatic vec_t mk(input logic [2:0] v, input logic s, input logic [2:0] rdy,
                              input logic we, input logic [4:0] wr, input logic [31:0] wd,
                              input logic [2:0] gid, input logic [7:0] cnt);
    vec_t t;
    t.valid = v;  t.stall = s;  t.ready = rdy;
    t.r0 = cr0;   t.r1 = cr1;   t.r2 = cr2;
    t.d0 = cd0;   t.d1 = cd1;   t.d2 = cd2;
    t.we = we;    t.wreg = wr;  t.wdata = wd;  t.gid = gid;  t.cnt = cnt;
    return t;
  endfunction

  task automatic add(input logic [2:0] v, input logic s, input logic [2:0] rdy,
                     input logic we, input logic [4:0] wr, input logic [31:0] wd,
                     input logic [2:0] gid, input logic [7:0] cnt);
    tbl.push_back(mk(v, s, rdy, we, wr, wd, gid, cnt));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clock);
    req_valid = v.valid;
    req_reg   = {v.r2, v.r1, v.r0};
    req_data  = {v.d2, v.d1, v.d0};
    wb_stall  = v.stall;
    #1;
    chk("req_ready", 32'(req_ready), 32'(v.ready));
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("ctrl_writeEnable", 32'(ctrl_writeEnable), 32'(e.we));
      chk("ctrl_writeReg",    32'(ctrl_writeReg),    32'(e.wreg));
      chk("data_writeReg",    data_writeReg,         e.wdata);
      chk("grant_id",         32'(grant_id),         32'(e.gid));
      chk("r0_drop_cnt",      32'(r0_drop_cnt),      32'(e.cnt));
    end
  endtask

  task automatic reset_cycle(input logic [2:0] v);
    @(negedge clock);
    ctrl_reset = 1'b0;
    req_valid  = v;
    wb_stall   = 1'b0;
    #1;
    chk("reset_ready", 32'(req_ready), 32'd0);
    @(posedge clock);
    #1;
    chk("reset_we",   32'(ctrl_writeEnable), 32'd0);
    chk("reset_reg",  32'(ctrl_writeReg),    32'd0);
    chk("reset_data", data_writeReg,         32'd0);
    chk("reset_gid",  32'(grant_id),         32'd0);
    chk("reset_cnt",  32'(r0_drop_cnt),      32'd0);
  endtask

  initial begin
    vec_t v;
    logic [7:0] exp_cnt;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    ctrl_reset = 1'b0;
    wb_stall   = 1'b0;
    req_valid  = 3'b000;
    req_reg    = {5'd3, 5'd2, 5'd1};
    req_data   = {32'hC2, 32'hB1, 32'hA0};

    // Reset held two cycles with all requesters asking.
    reset_cycle(3'b111);
    reset_cycle(3'b111);
    @(negedge clock);
    ctrl_reset = 1'b1;
    req_valid  = 3'b000;

    cr0 = 5'd1;  cr1 = 5'd2;  cr2 = 5'd3;
    cd0 = 32'hA0; cd1 = 32'hB1; cd2 = 32'hC2;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    add(3'b000, 0, 3'b000, 0, 5'd0, 32'h0,  3'd0, 8'd0);
    add(3'b111, 0, 3'b001, 1, 5'd1, 32'hA0, 3'd0, 8'd0);
    add(3'b111, 0, 3'b010, 1, 5'd2, 32'hB1, 3'd1, 8'd0);
    add(3'b111, 0, 3'b100, 1, 5'd3, 32'hC2, 3'd2, 8'd0);
    add(3'b111, 0, 3'b001, 1, 5'd1, 32'hA0, 3'd0, 8'd0);
    add(3'b000, 0, 3'b000, 0, 5'd1, 32'hA0, 3'd0, 8'd0);
`else
    add(3'b000, 0, 3'b000, 0, 5'd0, 32'h0,  3'd0, 8'd0);
    add(3'b011, 0, 3'b001, 1, 5'd1, 32'hA0, 3'd0, 8'd0);
    add(3'b011, 0, 3'b001, 1, 5'd1, 32'hA0, 3'd0, 8'd0);
    add(3'b011, 0, 3'b001, 1, 5'd1, 32'hA0, 3'd0, 8'd0);
    add(3'b010, 0, 3'b010, 1, 5'd2, 32'hB1, 3'd1, 8'd0);
    add(3'b110, 0, 3'b010, 1, 5'd2, 32'hB1, 3'd1, 8'd0);
    add(3'b100, 0, 3'b100, 1, 5'd3, 32'hC2, 3'd2, 8'd0);
    add(3'b000, 0, 3'b000, 0, 5'd3, 32'hC2, 3'd2, 8'd0);
`endif
    // Stall window, release, then a stall right behind an accepted write.
    add(3'b001, 0, 3'b001, 1, 5'd1, 32'hA0, 3'd0, 8'd0);
    add(3'b100, 1, 3'b000, 0, 5'd1, 32'hA0, 3'd0, 8'd0);
    add(3'b100, 1, 3'b000, 0, 5'd1, 32'hA0, 3'd0, 8'd0);
    add(3'b100, 1, 3'b000, 0, 5'd1, 32'hA0, 3'd0, 8'd0);
    add(3'b100, 0, 3'b100, 1, 5'd3, 32'hC2, 3'd2, 8'd0);
    add(3'b001, 0, 3'b001, 1, 5'd1, 32'hA0, 3'd0, 8'd0);
    add(3'b001, 1, 3'b000, 0, 5'd1, 32'hA0, 3'd0, 8'd0);
    add(3'b000, 0, 3'b000, 0, 5'd1, 32'hA0, 3'd0, 8'd0);
    // Write to r0 is consumed but suppressed.
    cr1 = 5'd0; cd1 = 32'hDEADBEEF;
    add(3'b010, 0, 3'b010, 0, 5'd0, 32'hDEADBEEF, 3'd1, 8'd1);
    add(3'b000, 0, 3'b000, 0, 5'd0, 32'hDEADBEEF, 3'd1, 8'd1);
    // Same-register collision between requesters 0 and 2.
    cr0 = 5'd7; cd0 = 32'h11; cr2 = 5'd7; cd2 = 32'h22;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    add(3'b101, 0, 3'b100, 1, 5'd7, 32'h22, 3'd2, 8'd1);
    add(3'b001, 0, 3'b001, 1, 5'd7, 32'h11, 3'd0, 8'd1);
    add(3'b000, 0, 3'b000, 0, 5'd7, 32'h11, 3'd0, 8'd1);
`else
    add(3'b101, 0, 3'b001, 1, 5'd7, 32'h11, 3'd0, 8'd1);
    add(3'b100, 0, 3'b100, 1, 5'd7, 32'h22, 3'd2, 8'd1);
    add(3'b000, 0, 3'b000, 0, 5'd7, 32'h22, 3'd2, 8'd1);
`endif

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    chk("collision_last_write_r7", rf[7], 32'h11);
`else
    chk("collision_last_write_r7", rf[7], 32'h22);
`endif

    // 300 more r0 writes: counter saturates at 255.
    cr0 = 5'd1; cd0 = 32'hA0; cr1 = 5'd0; cd1 = 32'hDEADBEEF; cr2 = 5'd3; cd2 = 32'hC2;
    for (int k = 0; k < 300; k++) begin
      exp_cnt = (k + 2 > 255) ? 8'd255 : 8'(k + 2);
      v = mk(3'b010, 0, 3'b010, 0, 5'd0, 32'hDEADBEEF, 3'd1, exp_cnt);
      step(v);
    end
    chk("r0_never_written", rf[0], 32'h0);

    // A request pending when reset asserts is dropped, not written.
    cr2 = 5'd9; cd2 = 32'h99;
    @(negedge clock);
    req_reg  = {cr2, cr1, cr0};
    req_data = {cd2, cd1, cd0};
    reset_cycle(3'b100);
    @(negedge clock);
    ctrl_reset = 1'b1;
    req_valid  = 3'b000;
    @(posedge clock);
    #1;
    chk("post_reset_we", 32'(ctrl_writeEnable), 32'd0);
    @(posedge clock);
    #1;
    chk("pending_discarded_r9", rf[9], 32'h0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
